// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: word geometry, drain FSM states and entry field widths.
package store_buffer_pkg;
    localparam int SB_WORD_BYTES = 4;
    localparam int SB_DATA_W     = 8 * SB_WORD_BYTES;
    localparam int SB_BE_W       = SB_WORD_BYTES;
    localparam int SB_OFFSET_W   = $clog2(SB_WORD_BYTES);

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_e;
endpackage

// File: rtl/store_buffer_bypass_merge.sv
// Combinational load bypass: merges matching buffered stores byte by byte, youngest entry winning each lane.
module sb_bypass_merge
    import store_buffer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int WADDR_W = 30,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WADDR_W-1:0]   ent_waddr_i,
    input  logic [DEPTH-1:0][SB_DATA_W-1:0] ent_data_i,
    input  logic [DEPTH-1:0][SB_BE_W-1:0]   ent_be_i,
    input  logic [DEPTH-1:0]                ent_valid_i,
    input  logic [PTR_W-1:0]                head_i,
    input  logic [WADDR_W-1:0]              ld_waddr_i,
    output logic [SB_DATA_W-1:0]            data_o,
    output logic [SB_BE_W-1:0]              covered_o
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        data_o    = '0;
        covered_o = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (ent_valid_i[idx] && (ent_waddr_i[idx] == ld_waddr_i)) begin
                for (int b = 0; b < SB_BE_W; b++) begin
                    if (ent_be_i[idx][b]) begin
                        covered_o[b]    = 1'b1;
                        data_o[8*b +: 8] = ent_data_i[idx][8*b +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// In-order word store buffer with byte-wise load bypass and a two-state drain FSM.
// Optional store coalescing into the youngest entry is enabled by STORE_BUFFER_COALESCE_EN.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    input  logic [ADDR_W-1:0]         enq_addr,
    input  logic [SB_DATA_W-1:0]      enq_data,
    input  logic [SB_BE_W-1:0]        enq_be,
    output logic                      enq_ready,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [SB_BE_W-1:0]        ld_be,
    output logic                      ld_hit,
    output logic                      ld_partial,
    output logic [SB_DATA_W-1:0]      ld_data,
    input  logic                      drain_allow,
    input  logic                      flush_req,
    output logic                      drain_valid,
    output logic [ADDR_W-1:0]         drain_addr,
    output logic [SB_DATA_W-1:0]      drain_data,
    output logic [SB_BE_W-1:0]        drain_be,
    input  logic                      drain_ready,
    output logic                      sb_empty,
    output logic [$clog2(DEPTH):0]    sb_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int WADDR_W = ADDR_W - SB_OFFSET_W;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0][WADDR_W-1:0]   waddr_q;
    logic [DEPTH-1:0][SB_DATA_W-1:0] data_q;
    logic [DEPTH-1:0][SB_BE_W-1:0]   be_q;
    logic [PTR_W-1:0]                head_q, tail_q, youngest, offset;
    logic [PTR_W:0]                  count_q, count_d;
    sb_state_e                       state_q, state_d;
    logic [WADDR_W-1:0]              drain_waddr_q;
    logic [SB_DATA_W-1:0]            drain_data_q;
    logic [SB_BE_W-1:0]              drain_be_q;
    logic [WADDR_W-1:0]              enq_waddr;
    logic [DEPTH-1:0]                valid_mask;
    logic [SB_BE_W-1:0]              covered;
    logic                            start_req, do_pop, do_enq, do_alloc, do_merge, merge_ok;
    logic                            unused_addr_bits;

    assign enq_waddr        = enq_addr[ADDR_W-1:SB_OFFSET_W];
    assign unused_addr_bits = ^{enq_addr[SB_OFFSET_W-1:0], ld_addr[SB_OFFSET_W-1:0]};
    assign youngest         = tail_q - PTR_W'(1);
    assign start_req        = (state_q == SB_IDLE) && (count_q != '0) && (drain_allow || flush_req);
    assign do_pop           = (state_q == SB_REQ) && drain_ready;

`ifdef STORE_BUFFER_COALESCE_EN
    // The head may not absorb a merge once it is, or is about to be, copied into the drain registers.
    assign merge_ok = (count_q != '0) && (waddr_q[youngest] == enq_waddr) &&
                      !((youngest == head_q) && ((state_q == SB_REQ) || start_req));
`else
    assign merge_ok = 1'b0;
`endif

    assign enq_ready = (count_q < DEPTH_C) || merge_ok;
    assign do_enq    = enq_valid && enq_ready;
    assign do_merge  = do_enq && merge_ok;
    assign do_alloc  = do_enq && !merge_ok;
    assign count_d   = count_q + (PTR_W+1)'(do_alloc) - (PTR_W+1)'(do_pop);

    always_comb begin
        state_d = state_q;
        if (start_req) begin
            state_d = SB_REQ;
        end else if (do_pop) begin
            state_d = SB_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SB_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            drain_waddr_q <= '0;
            drain_data_q  <= '0;
            drain_be_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (do_alloc) tail_q <= tail_q + PTR_W'(1);
            if (do_pop)   head_q <= head_q + PTR_W'(1);
            if (start_req) begin
                drain_waddr_q <= waddr_q[head_q];
                drain_data_q  <= data_q[head_q];
                drain_be_q    <= be_q[head_q];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waddr_q <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else if (do_alloc) begin
            waddr_q[tail_q] <= enq_waddr;
            data_q[tail_q]  <= enq_data;
            be_q[tail_q]    <= enq_be;
        end else if (do_merge) begin
            be_q[youngest] <= be_q[youngest] | enq_be;
            for (int b = 0; b < SB_BE_W; b++) begin
                if (enq_be[b]) data_q[youngest][8*b +: 8] <= enq_data[8*b +: 8];
            end
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        valid_mask = '0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = PTR_W'(i) - head_q;
            valid_mask[i] = {1'b0, offset} < count_q;
        end
    end

    sb_bypass_merge #(
        .DEPTH   (DEPTH),
        .WADDR_W (WADDR_W)
    ) u_bypass (
        .ent_waddr_i (waddr_q),
        .ent_data_i  (data_q),
        .ent_be_i    (be_q),
        .ent_valid_i (valid_mask),
        .head_i      (head_q),
        .ld_waddr_i  (ld_addr[ADDR_W-1:SB_OFFSET_W]),
        .data_o      (ld_data),
        .covered_o   (covered)
    );

    assign ld_hit      = (ld_be != '0) && ((covered & ld_be) == ld_be);
    assign ld_partial  = ((covered & ld_be) != '0) && !ld_hit;
    assign drain_valid = (state_q == SB_REQ);
    assign drain_addr  = {drain_waddr_q, {SB_OFFSET_W{1'b0}}};
    assign drain_data  = drain_data_q;
    assign drain_be    = drain_be_q;
    assign sb_empty    = (count_q == '0);
    assign sb_count    = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: bypass vector table, drain scoreboard, full/wrap, backpressure, flush and reset corners.
module tb_store_buffer;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        enq_valid, enq_ready;
   logic [31:0] enq_addr, enq_data;
   logic [3:0]  enq_be;
   logic [31:0] ld_addr, ld_data;
   logic [3:0]  ld_be;
   logic        ld_hit, ld_partial;
   logic        drain_allow, flush_req, drain_valid, drain_ready;
   logic [31:0] drain_addr, drain_data;
   logic [3:0]  drain_be;
   logic        sb_empty;
   logic [2:0]  sb_count;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data), .enq_be(enq_be), .enq_ready(enq_ready),
      .ld_addr(ld_addr), .ld_be(ld_be), .ld_hit(ld_hit), .ld_partial(ld_partial), .ld_data(ld_data),
      .drain_allow(drain_allow), .flush_req(flush_req), .drain_valid(drain_valid),
      .drain_addr(drain_addr), .drain_data(drain_data), .drain_be(drain_be), .drain_ready(drain_ready),
      .sb_empty(sb_empty), .sb_count(sb_count)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } drain_t;

   typedef struct {
      logic [31:0] ldAddr;
      logic [3:0]  ldBe;
      logic        expHit;
      logic        expPartial;
      logic [31:0] expData;
   } bypass_vec_t;

   drain_t      expQ[$];
   drain_t      monExp;
   bypass_vec_t vecs[10];
   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] snapAddr, snapData;
   logic [3:0]  snapBe;

   // Compare one observed value against the bench's expectation and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a load probe and let the combinational bypass settle.
   task automatic applyStimulus(input bypass_vec_t v);
      ld_addr = v.ldAddr;
      ld_be   = v.ldBe;
      #2;
   endtask

   // Hold a store until the buffer takes it, then record the drain it should produce.
   task automatic enqueue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      bit fired = 1'b0;
      enq_valid = 1'b1;
      enq_addr  = a;
      enq_data  = d;
      enq_be    = b;
      for (int n = 0; n < 100 && !fired; n++) begin
         fired = enq_ready;
         step();
      end
      enq_valid = 1'b0;
      if (fired) begin
         expQ.push_back('{addr: a & ~32'h3, data: d, be: b});
      end else begin
         checkCount++;
         $display("[TB] FAIL enqueue_timeout addr %h: got no accept, expected accept", a);
      end
   endtask

   task automatic waitEmpty(input int bound);
      for (int n = 0; n < bound && !sb_empty; n++) step();
      checkOutput("wait_sb_empty", 32'(sb_empty), 32'd1);
   endtask

   task automatic waitDrainValid(input int bound);
      for (int n = 0; n < bound && !drain_valid; n++) step();
      checkOutput("wait_drain_valid", 32'(drain_valid), 32'd1);
   endtask

   // Scoreboard: every accepted drain handshake must match the oldest outstanding store.
   always @(negedge clk) begin
      if (reset && drain_valid && drain_ready) begin
         if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_drain: got addr %h data %h, expected no drain", drain_addr, drain_data);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("drain_addr", drain_addr, monExp.addr);
            checkOutput("drain_data", drain_data, monExp.data);
            checkOutput("drain_be", 32'(drain_be), 32'(monExp.be));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{32'h105,      4'b0010, 1'b1, 1'b0, 32'h00007700};
      vecs[1] = '{32'h104,      4'b0011, 1'b0, 1'b1, 32'h00007700};
      vecs[2] = '{32'h100,      4'b0001, 1'b1, 1'b0, 32'hCC000022};
      vecs[3] = '{32'h100,      4'b1111, 1'b0, 1'b1, 32'hCC000022};
      vecs[4] = '{32'h100,      4'b1001, 1'b1, 1'b0, 32'hCC000022};
      vecs[5] = '{32'h108,      4'b1111, 1'b0, 1'b0, 32'h00000000};
      vecs[6] = '{32'h100,      4'b0000, 1'b0, 1'b0, 32'hCC000022};
      vecs[7] = '{32'h104,      4'b0100, 1'b0, 1'b0, 32'h00007700};
      vecs[8] = '{32'h107,      4'b0010, 1'b1, 1'b0, 32'h00007700};
      vecs[9] = '{32'h80000104, 4'b0010, 1'b0, 1'b0, 32'h00000000};

      reset = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_be = '0;
      ld_addr = 32'h100; ld_be = 4'hF; drain_allow = 1'b0; flush_req = 1'b0; drain_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_enq_ready", 32'(enq_ready), 32'd1);
      checkOutput("rst_sb_empty", 32'(sb_empty), 32'd1);
      checkOutput("rst_sb_count", 32'(sb_count), 32'd0);
      checkOutput("rst_drain_valid", 32'(drain_valid), 32'd0);
      checkOutput("rst_drain_addr", drain_addr, 32'd0);
      checkOutput("rst_drain_data", drain_data, 32'd0);
      checkOutput("rst_drain_be", 32'(drain_be), 32'd0);
      checkOutput("rst_ld_hit", 32'(ld_hit), 32'd0);
      checkOutput("rst_ld_partial", 32'(ld_partial), 32'd0);
      checkOutput("rst_ld_data", ld_data, 32'd0);
      reset = 1'b1;
      step();

      // Fill the buffer with drains blocked, then probe the bypass table.
      enqueue(32'h104, 32'h00007700, 4'b0010);
      checkOutput("count_after_one", 32'(sb_count), 32'd1);
      enqueue(32'h100, 32'h00000011, 4'b0001);
      enqueue(32'h100, 32'h00000022, 4'b0001);
      enqueue(32'h102, 32'hCC000000, 4'b1000);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("bypass[%0d].hit", i), 32'(ld_hit), 32'(vecs[i].expHit));
         checkOutput($sformatf("bypass[%0d].partial", i), 32'(ld_partial), 32'(vecs[i].expPartial));
         checkOutput($sformatf("bypass[%0d].data", i), ld_data, vecs[i].expData);
         step();
      end

      // Full: a held store waits until a pop frees a slot.
      checkOutput("full_enq_ready", 32'(enq_ready), 32'd0);
      checkOutput("full_count", 32'(sb_count), 32'd4);
      enq_valid = 1'b1; enq_addr = 32'h200; enq_data = 32'h0BADF00D; enq_be = 4'hF;
      step();
      step();
      checkOutput("full_hold_count", 32'(sb_count), 32'd4);
      drain_allow = 1'b1;
      enqueue(32'h200, 32'h0BADF00D, 4'hF);
      for (int i = 0; i < 10; i++) begin
         enqueue(32'h1000 + 32'(4 * i), $urandom, 4'((i % 15) + 1));
      end
      waitEmpty(200);

      // Backpressure: outputs hold in REQ while drain_allow toggles.
      drain_ready = 1'b0;
      enqueue(32'h300, 32'hDEADBEEF, 4'hF);
      enqueue(32'h306, 32'h12345678, 4'b0110);
      waitDrainValid(20);
      snapAddr = drain_addr; snapData = drain_data; snapBe = drain_be;
      checkOutput("bp_first_addr", snapAddr, 32'h300);
      for (int c = 0; c < 5; c++) begin
         drain_allow = c[0];
         step();
         checkOutput("bp_valid_held", 32'(drain_valid), 32'd1);
         checkOutput("bp_addr_stable", drain_addr, snapAddr);
         checkOutput("bp_data_stable", drain_data, snapData);
         checkOutput("bp_be_stable", 32'(drain_be), 32'(snapBe));
      end
      drain_allow = 1'b0;
      drain_ready = 1'b1;
      step();

      // Flush drains with drain_allow low.
      enqueue(32'h310, 32'hA5A5A5A5, 4'b0011);
      enqueue(32'h314, 32'h5A5A5A5A, 4'b1100);
      step();
      step();
      checkOutput("noflush_drain_valid", 32'(drain_valid), 32'd0);
      checkOutput("noflush_count", 32'(sb_count), 32'd3);
      flush_req = 1'b1;
      waitEmpty(50);
      flush_req = 1'b0;

      // Drain latency: enqueue at N, REQ at N+1, pop at N+2.
      drain_allow = 1'b1;
      enqueue(32'h400, 32'hFEEDFACE, 4'hF);
      checkOutput("lat_n_valid", 32'(drain_valid), 32'd0);
      checkOutput("lat_n_count", 32'(sb_count), 32'd1);
      step();
      checkOutput("lat_n1_valid", 32'(drain_valid), 32'd1);
      checkOutput("lat_n1_addr", drain_addr, 32'h400);
      step();
      checkOutput("lat_n2_empty", 32'(sb_empty), 32'd1);

      // Reset while a request is outstanding.
      drain_ready = 1'b0;
      enqueue(32'h500, 32'h11112222, 4'hF);
      enqueue(32'h504, 32'h33334444, 4'hF);
      waitDrainValid(20);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstmid_drain_valid", 32'(drain_valid), 32'd0);
      checkOutput("rstmid_count", 32'(sb_count), 32'd0);
      checkOutput("rstmid_empty", 32'(sb_empty), 32'd1);
      ld_addr = 32'h500; ld_be = 4'hF;
      #1;
      checkOutput("rstmid_ld_hit", 32'(ld_hit), 32'd0);
      expQ.delete();
      #3;
      reset = 1'b1;
      step();
      drain_ready = 1'b1;
      repeat (6) step();
      checkOutput("post_rst_drain_valid", 32'(drain_valid), 32'd0);
      checkOutput("post_rst_count", 32'(sb_count), 32'd0);

      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
